// File: rtl/hysteresis_tracker.sv
// Hysteresis tracker: final Canny stage. Resolves intermediate pixels of a
// 3-level stream (0 / intermediate / STRONG_VAL) into binary edges using the
// 8-neighbourhood, streaming in raster order through two line buffers.
//
// state | meaning
// FILL  | priming the delay line, inputs accepted, nothing emitted
// RUN   | one output per accepted input, one clock after acceptance
// FLUSH | input stalled, zeros shifted in, remaining IMG_WIDTH+1 outputs
module hysteresis_tracker #(
    parameter int          IMG_WIDTH  = 512,
    parameter int          IMG_HEIGHT = 512,
    parameter logic [7:0]  STRONG_VAL = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       frame_done
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = $clog2(IMG_HEIGHT);
    localparam int FW   = $clog2(IMG_WIDTH + 1);

    localparam logic [CW-1:0] IN_LAST    = CW'(NPIX - 1);
    localparam logic [CW-1:0] FILL_LAST  = CW'(IMG_WIDTH);
    localparam logic [XW-1:0] COL_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_lb_a [IMG_WIDTH];   // pixel from one line ago
    logic [7:0]      r_lb_b [IMG_WIDTH];   // pixel from two lines ago
    logic [7:0]      r_win  [3][2];        // two newest window columns
    logic [7:0]      w_win  [3][3];        // window after the pending shift

    logic [XW-1:0]   r_ptr;
    logic [CW-1:0]   r_in_cnt;
    logic [XW-1:0]   r_ccol;
    logic [YW-1:0]   r_crow;
    logic [FW-1:0]   r_flush_cnt;
    logic [7:0]      r_dout;
    logic            r_dout_valid;
    logic            r_frame_done;

    logic            w_accept;
    logic            w_shift;
    logic            w_emit;
    logic            w_fill_done;
    logic            w_last_in;
    logic            w_flush_last;
    logic [7:0]      w_pix_in;
    logic            w_border;
    logic            w_nbr_strong;
    logic [7:0]      w_res;

    // Handshake and shift qualifiers; FLUSH pads with zeros regardless of input.
    always_comb begin
        in_ready     = (r_state != S_FLUSH);
        w_accept     = data_in_valid && (r_state != S_FLUSH);
        w_shift      = w_accept || (r_state == S_FLUSH);
        w_emit       = (w_accept && (r_state == S_RUN)) || (r_state == S_FLUSH);
        w_fill_done  = w_accept && (r_state == S_FILL) && (r_in_cnt == FILL_LAST);
        w_last_in    = w_accept && (r_in_cnt == IN_LAST);
        w_flush_last = (r_state == S_FLUSH) && (r_flush_cnt == FLUSH_LAST);
        w_pix_in     = (r_state == S_FLUSH) ? 8'd0 : data_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FILL;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_fill_done)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last_in)    w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_flush_last) w_state_nxt = S_FILL;
            default:                   w_state_nxt = S_FILL;
        endcase
    end

    // Window as it will look after this cycle's shift; resolution works on it
    // so the registered output lands one clock after acceptance.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_win[r][0] = r_win[r][0];
            w_win[r][1] = r_win[r][1];
        end
        w_win[0][2] = r_lb_b[r_ptr];
        w_win[1][2] = r_lb_a[r_ptr];
        w_win[2][2] = w_pix_in;
    end

    // Resolution of the window centre; border positions mask stale buffer data.
    always_comb begin
        w_nbr_strong = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1) && (w_win[r][c] == STRONG_VAL))
                    w_nbr_strong = 1'b1;
            end
        end
        w_border = (r_crow == '0) || (r_crow == ROW_LAST) ||
                   (r_ccol == '0) || (r_ccol == COL_LAST);
        w_res = 8'd0;
        if (w_border)                   w_res = 8'd0;
        else if (w_win[1][1] == STRONG_VAL) w_res = STRONG_VAL;
        else if (w_win[1][1] == 8'd0)   w_res = 8'd0;
        else if (w_nbr_strong)          w_res = STRONG_VAL;
    end

    // Line buffers and window columns; contents are never cleared.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb_a[r_ptr] <= w_pix_in;
            r_lb_b[r_ptr] <= r_lb_a[r_ptr];
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= w_win[r][1];
                r_win[r][1] <= w_win[r][2];
            end
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_in_cnt     <= '0;
            r_ccol       <= '0;
            r_crow       <= '0;
            r_flush_cnt  <= '0;
            r_dout       <= 8'd0;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dout_valid <= w_emit;
            r_frame_done <= w_flush_last;
            if (w_shift)
                r_ptr <= (r_ptr == COL_LAST) ? '0 : r_ptr + XW'(1);
            if (w_accept)
                r_in_cnt <= w_last_in ? '0 : r_in_cnt + CW'(1);
            if (r_state == S_FLUSH)
                r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + FW'(1);
            if (w_emit) begin
                r_dout <= w_res;
                if (r_ccol == COL_LAST) begin
                    r_ccol <= '0;
                    r_crow <= (r_crow == ROW_LAST) ? '0 : r_crow + YW'(1);
                end else begin
                    r_ccol <= r_ccol + XW'(1);
                end
            end
        end
    end

    assign data_out       = r_dout;
    assign data_out_valid = r_dout_valid;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_hysteresis_tracker.sv
// Bench for hysteresis_tracker on a 4x4 frame: frame-level reference model
// plus per-cycle output/handshake checking and literal scenario checks.
module tb_hysteresis_tracker;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef logic [7:0] frame_t [NPIX];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       data_in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_done;

    hysteresis_tracker #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .STRONG_VAL(8'd255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .in_ready      (in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .frame_done    (frame_done)
    );

    initial forever #5 clk = ~clk;

    int     n_chk = 0;
    int     n_fail = 0;
    frame_t fbuf;
    frame_t out_log;
    frame_t s1_log;
    int     n_valid = 0;
    int     n_fd = 0;
    int     n_rdy_low = 0;
    int     acc = 0;
    int     flush_left = 0;
    int     exp_k = 0;
    logic   exp_v = 1'b0;
    logic   exp_fd = 1'b0;
    logic   exp_rdy = 1'b1;
    logic [7:0] exp_d = 8'd0;
    bit     armed = 1'b0;

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Direct application of the resolution rule to pixel k of the current frame.
    function automatic logic [7:0] resolve(int k);
        int r = k / W;
        int c = k % W;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
        if (fbuf[k] == 8'd255) return 8'd255;
        if (fbuf[k] == 8'd0) return 8'd0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && fbuf[(r + dr) * W + c + dc] == 8'd255)
                    return 8'd255;
        return 8'd0;
    endfunction

    // Runs at every negedge: check outputs against the prediction, then
    // predict the next edge from the inputs now being presented.
    task automatic monitor_step();
        if (armed) begin
            chk("data_out_valid", int'(data_out_valid), int'(exp_v));
            chk("data_out", int'(data_out), int'(exp_d));
            chk("frame_done", int'(frame_done), int'(exp_fd));
            chk("in_ready", int'(in_ready), int'(exp_rdy));
            if (data_out_valid) begin
                out_log[exp_k] = data_out;
                n_valid++;
            end
            if (frame_done) n_fd++;
            if (!in_ready) n_rdy_low++;
        end
        if (rst) begin
            acc = 0; flush_left = 0;
            exp_v = 1'b0; exp_d = 8'd0; exp_fd = 1'b0; exp_rdy = 1'b1;
            armed = 1'b1;
        end else begin
            exp_v = 1'b0;
            exp_fd = 1'b0;
            if (flush_left > 0) begin
                exp_k = NPIX - flush_left;
                exp_v = 1'b1;
                exp_d = resolve(exp_k);
                exp_fd = (flush_left == 1);
                flush_left--;
                if (flush_left == 0) acc = 0;
            end else if (data_in_valid) begin
                fbuf[acc] = data_in;
                acc++;
                if (acc >= W + 2) begin
                    exp_k = acc - W - 2;
                    exp_v = 1'b1;
                    exp_d = resolve(exp_k);
                end
                if (acc == NPIX) flush_left = W + 1;
            end
            exp_rdy = (flush_left == 0);
        end
    endtask

    // mode 0: valid every cycle, 1: every third cycle, 2: random gaps.
    // hold keeps data_in_valid high (with junk data) while in_ready is low.
    task automatic drive(frame_t fr, int count, int mode, bit hold);
        int i = 0;
        int phase = 0;
        int budget = 0;
        bit want;
        while (i < count && budget < 300) begin
            @(posedge clk); #1;
            budget++;
            want = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 3 == 0) : ($urandom_range(0, 2) != 0);
            phase++;
            if (in_ready && want) begin
                data_in_valid = 1'b1; data_in = fr[i]; i++;
            end else if (hold) begin
                data_in_valid = 1'b1; data_in = 8'hFF;
            end else begin
                data_in_valid = 1'b0; data_in = 8'($urandom);
            end
        end
        chk("drive_budget", i, count);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_frames(int target);
        int b = 0;
        while (n_fd < target && b < 300) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk("frame_done_count", n_fd, target);
    endtask

    task automatic chk_log(string nm, frame_t ref_f);
        for (int k = 0; k < NPIX; k++) chk(nm, int'(out_log[k]), int'(ref_f[k]));
    endtask

    initial begin
        frame_t f_all, f_s2, f_s3a, f_s3b, f_rnd, pat1, pat2, zeros;
        int base_v, base_r, base_fd;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        for (int k = 0; k < NPIX; k++) begin
            f_all[k] = 8'd255; f_s2[k] = 8'd0; f_s3a[k] = 8'd0; f_s3b[k] = 8'd0;
            zeros[k] = 8'd0;
            pat1[k]  = (k == 5 || k == 6 || k == 9 || k == 10) ? 8'd255 : 8'd0;
            pat2[k]  = (k == 5 || k == 10) ? 8'd255 : 8'd0;
        end
        f_s2[5] = 8'd100; f_s2[10] = 8'd255;
        f_s3a[5] = 8'd100;
        f_s3b[6] = 8'd100; f_s3b[0] = 8'd255;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_valid", int'(data_out_valid), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_in_ready", int'(in_ready), 1);

        // All strong, continuous valid.
        base_v = n_valid; base_r = n_rdy_low; base_fd = n_fd;
        drive(f_all, NPIX, 0, 1'b0); idle(); wait_frames(base_fd + 1);
        chk("s1_valids", n_valid - base_v, 16);
        chk("s1_ready_low", n_rdy_low - base_r, 5);
        chk_log("s1_out", pat1);
        s1_log = out_log;

        // Weak next to strong gets promoted.
        base_v = n_valid; base_fd = n_fd;
        drive(f_s2, NPIX, 0, 1'b0); idle(); wait_frames(base_fd + 1);
        chk("s2_valids", n_valid - base_v, 16);
        chk_log("s2_out", pat2);

        // Isolated weak, and a strong pixel outside the neighbourhood.
        base_fd = n_fd;
        drive(f_s3a, NPIX, 0, 1'b0); idle(); wait_frames(base_fd + 1);
        chk_log("s3a_out", zeros);
        base_fd = n_fd;
        drive(f_s3b, NPIX, 0, 1'b0); idle(); wait_frames(base_fd + 1);
        chk("s3b_pix_1_2", int'(out_log[6]), 0);
        chk_log("s3b_out", zeros);

        // All strong again, valid every third cycle.
        base_v = n_valid; base_fd = n_fd;
        drive(f_all, NPIX, 1, 1'b0); idle(); wait_frames(base_fd + 1);
        chk("s4_valids", n_valid - base_v, 16);
        chk_log("s4_out", s1_log);

        // Reset after 7 accepted pixels, then a fresh frame.
        for (int k = 0; k < NPIX; k++) f_rnd[k] = 8'($urandom_range(0, 255));
        drive(f_rnd, 7, 0, 1'b0);
        @(posedge clk); #1 data_in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("valid_after_rst", int'(data_out_valid), 0);
        chk("ready_after_rst", int'(in_ready), 1);
        base_v = n_valid; base_fd = n_fd;
        drive(f_s2, NPIX, 0, 1'b0); idle(); wait_frames(base_fd + 1);
        chk("s5_valids", n_valid - base_v, 16);
        chk_log("s5_out", pat2);

        // Back-to-back frames with valid held high through FLUSH.
        base_v = n_valid; base_r = n_rdy_low; base_fd = n_fd;
        drive(f_s2, NPIX, 0, 1'b1);
        drive(f_all, NPIX, 0, 1'b1);
        idle(); wait_frames(base_fd + 2);
        chk("s6_valids", n_valid - base_v, 32);
        chk("s6_ready_low", n_rdy_low - base_r, 10);
        chk_log("s6_out", pat1);

        // Random 3-level frames with random gaps.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NPIX; k++) begin
                case ($urandom_range(0, 2))
                    0:       f_rnd[k] = 8'd0;
                    1:       f_rnd[k] = 8'd255;
                    default: f_rnd[k] = 8'($urandom_range(1, 254));
                endcase
            end
            base_v = n_valid; base_fd = n_fd;
            drive(f_rnd, NPIX, 2, 1'b0); idle(); wait_frames(base_fd + 1);
            chk("rnd_valids", n_valid - base_v, 16);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
